// File: rtl/or_arb_pkg.sv
// ---------------------------------------------------------------------------
// or_arb_pkg
// Shared definitions for the OR-resource round-robin arbiter.
//   - FSM state type and encodings (IDLE, GRANT, REL)
//   - Default sizing constants used as parameter defaults by the top level
// ---------------------------------------------------------------------------
package or_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_GRANT = 2'd1;
    localparam state_t ST_REL   = 2'd2;

    localparam int DEFAULT_N        = 3;
    localparam int DEFAULT_MAX_HOLD = 15;
    localparam int DEFAULT_CNT_W    = 4;

endpackage : or_arb_pkg

// File: rtl/or_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Scans req starting at ptr and
// wrapping modulo N; the first set bit wins.
// Ports:
//   req      in  N    request vector
//   ptr      in  IW   index with highest priority this cycle
//   pick     out N    one-hot winner, zero when req is zero
//   pick_id  out IW   index of the winner, zero when req is zero
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_id
);

    logic          found;
    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int i = 0; i < N; i++) begin
            // Offset from ptr, folded back into 0..N-1 (ptr < N, so one
            // subtraction is enough).
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            // found latches the first hit so pick can never be multi-hot.
            if (!found && req[jj]) begin
                found    = 1'b1;
                pick[jj] = 1'b1;
                pick_id  = jj;
            end
        end
    end

endmodule : rr_pick

// File: rtl/or_rr_arbiter.sv
// ---------------------------------------------------------------------------
// or_rr_arbiter
// Round-robin arbiter sequencing N requesters onto one shared OR datapath.
// Exactly one grant at a time; a grant ends on done, on the grantee dropping
// its request, or on the hold limit (which also pulses timeout).
//
// Handshake: req[i] is a level request held high for as long as requester i
// wants the resource. gnt[i] high means requester i owns the resource. The
// owner ends its tenure by pulsing done (sampled only while busy) or by
// lowering req[i]; either way gnt drops on the next cycle, and at least one
// gnt-low cycle separates any two grants.
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   req        in   N     request lines
//   done       in   1     release strobe from current grantee
//   gnt        out  N     one-hot grant, zero when idle
//   gnt_id     out  IW    index of current grantee, valid while busy
//   busy       out  1     a grant is active
//   any_req    out  1     registered OR of req
//   timeout    out  1     one-cycle pulse on forced release
//   state_dbg  out  2     FSM state (debug)
//   ptr_dbg    out  IW    round-robin priority pointer (debug)
// ---------------------------------------------------------------------------
module or_rr_arbiter
    import or_arb_pkg::*;
#(
    parameter  int N        = DEFAULT_N,
    parameter  int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter  int CNT_W    = DEFAULT_CNT_W,
    localparam int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          any_req,
    output logic          timeout,
    output state_t        state_dbg,
    output logic [IW-1:0] ptr_dbg
);

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]   pick;
    logic [IW-1:0]  pick_id;
    logic           owner_req;
    logic           hold_limit;
    logic           release_now;
    logic [IW-1:0]  next_ptr;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr),
        .pick    (pick),
        .pick_id (pick_id)
    );

    assign owner_req   = req[gnt_id];
    assign hold_limit  = (cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now = done || !owner_req || hold_limit;
    assign next_ptr    = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;

    assign state_dbg = state;
    assign ptr_dbg   = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            any_req <= 1'b0;
            timeout <= 1'b0;
        end else begin
            any_req <= |req;
            timeout <= 1'b0;
            case (state)
                // REL is the mandatory gnt-low cycle after a release. The next
                // grant is decided at its closing edge, so the gap is exactly
                // one cycle; with nothing pending it falls back to IDLE.
                ST_IDLE, ST_REL: begin
                    if (|req) begin
                        gnt    <= pick;
                        gnt_id <= pick_id;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_GRANT;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr     <= next_ptr;
                        cnt     <= '0;
                        state   <= ST_REL;
                        // A voluntary release in the limit cycle wins over
                        // the forced one, so no timeout pulse then.
                        timeout <= hold_limit && !done && owner_req;
                    end else begin
                        cnt     <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule : or_rr_arbiter

// File: tb/tb_or_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_or_rr_arbiter
// Directed bench for or_rr_arbiter (N=3, MAX_HOLD=15). Inputs change and
// outputs are sampled 1ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_or_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       any_req;
    logic       timeout;
    logic [1:0] state_dbg;
    logic [1:0] ptr_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // -------------------------------------------------------------- clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    or_rr_arbiter #(
        .N        (3),
        .MAX_HOLD (15),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .any_req   (any_req),
        .timeout   (timeout),
        .state_dbg (state_dbg),
        .ptr_dbg   (ptr_dbg)
    );

    // -------------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},  8'(gnt),  8'h00);
        check({tag, "_busy"}, 8'(busy), 8'h00);
    endtask

    // -------------------------------------------------------------- stimulus
    logic [2:0] seq [4];

    initial begin
        seq[0] = 3'b001;
        seq[1] = 3'b010;
        seq[2] = 3'b100;
        seq[3] = 3'b001;

        // Reset held with all requests asserted: everything stays zero.
        rst_n = 1'b0;
        req   = 3'b111;
        done  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_outputs("rst");
            check("rst_any_req", 8'(any_req), 8'h00);
            check("rst_timeout", 8'(timeout), 8'h00);
            check("rst_state",   8'(state_dbg), 8'h00);
        end

        // First grant after reset goes to requester 0.
        rst_n = 1'b1;
        tick();
        check("rot_first_gnt", 8'(gnt),     8'(seq[0]));
        check("rot_first_id",  8'(gnt_id),  8'h00);
        check("rot_first_bsy", 8'(busy),    8'h01);
        check("rot_any_req",   8'(any_req), 8'h01);

        // Rotation: done two cycles after each grant, one gap cycle between.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rot_hold", 8'(gnt), 8'(seq[k]));
            done = 1'b1;
            tick();
            done = 1'b0;
            check_idle_outputs("rot_gap");
            check("rot_gap_to",  8'(timeout), 8'h00);
            check("rot_gap_ptr", 8'(ptr_dbg), 8'((k + 1) % 3));
            tick();
            check("rot_next_gnt", 8'(gnt),    8'(seq[k + 1]));
            check("rot_next_id",  8'(gnt_id), 8'((k + 1) % 3));
        end

        // Drop release: grantee 0 lowers its request.
        req = 3'b100;
        tick();
        check_idle_outputs("drop");
        check("drop_ptr", 8'(ptr_dbg), 8'h01);
        check("drop_to",  8'(timeout), 8'h00);
        req = 3'b101;
        tick();
        check("drop_next_gnt", 8'(gnt),    8'h04);
        check("drop_next_id",  8'(gnt_id), 8'h02);

        // Async reset mid-grant, asserted away from any clock edge.
        req = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("arst");
        check("arst_timeout", 8'(timeout),   8'h00);
        check("arst_state",   8'(state_dbg), 8'h00);
        check("arst_ptr",     8'(ptr_dbg),   8'h00);
        tick();
        check_idle_outputs("arst_hold");
        rst_n = 1'b1;
        tick();
        check("arst_first_gnt", 8'(gnt), 8'h01);

        // Move to a single persistent requester 1 (drop release of 0 first).
        req = 3'b010;
        tick();
        check_idle_outputs("to_prep");
        tick();
        check("to_gnt0", 8'(gnt), 8'h02);

        // Timeout: 15 cycles of grant, then forced release.
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to_hold_gnt", 8'(gnt),     8'h02);
            check("to_hold_to",  8'(timeout), 8'h00);
        end
        tick();
        check_idle_outputs("to_rel");
        check("to_pulse", 8'(timeout), 8'h01);
        check("to_ptr",   8'(ptr_dbg), 8'h02);
        tick();
        check("to_regnt",     8'(gnt),     8'h02);
        check("to_pulse_end", 8'(timeout), 8'h00);

        // Done in the limit cycle: normal release, no timeout. Other
        // requesters toggle meanwhile without disturbing the grant.
        for (int i = 0; i < 14; i++) begin
            req = (i % 2 == 1) ? 3'b111 : 3'b010;
            tick();
            check("lim_hold_gnt", 8'(gnt), 8'h02);
        end
        req  = 3'b010;
        done = 1'b1;
        tick();
        done = 1'b0;
        check_idle_outputs("lim_rel");
        check("lim_timeout", 8'(timeout), 8'h00);
        tick();
        check("lim_regnt", 8'(gnt), 8'h02);

        // All requests gone: release, any_req falls, FSM back to IDLE.
        req = 3'b000;
        tick();
        check_idle_outputs("empty_rel");
        check("empty_any_req", 8'(any_req), 8'h00);
        tick();
        check("empty_state", 8'(state_dbg), 8'h00);
        check("empty_gnt",   8'(gnt),       8'h00);

        // Pointer at 2 after releasing requester 1; only req[0] set -> wrap.
        req = 3'b001;
        tick();
        check("wrap_gnt", 8'(gnt),    8'h01);
        check("wrap_id",  8'(gnt_id), 8'h00);
        check("wrap_any", 8'(any_req), 8'h01);

        // -------------------------------------------------------------- report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_or_rr_arbiter
